// File: rtl/polaris_pkg.sv
// Shared definitions for the Polaris instruction-fetch front end.
// Holds the I-master size encodings, the default reset vector, the prefetch
// FSM state encoding and the queue entry layout.
package polaris_pkg;

  // I-master transfer size encodings
  localparam logic [1:0] ISIZ_NONE = 2'b00;
  localparam logic [1:0] ISIZ_WORD = 2'b10;

  // First fetch address after reset (truncated to the address width in use)
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

  // Prefetcher states: IDLE waits for queue space, FETCH has a live request at
  // the fetch pc, DISCARD finishes a bus cycle whose data is no longer wanted.
  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

  // One buffered fetch result. The pc is held at full 64-bit width; narrower
  // address configurations zero-extend into it.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/polaris_fetch_fifo.sv
// Circular buffer of {pc, instruction} entries for the fetch queue.
// Ports:
//   clk_i, reset_ni   clock, asynchronous active-low reset (control state only)
//   flush_i           discard all entries; overrides push and pop
//   push_i, entry_i   write one entry at the tail
//   pop_i             advance the head; ignored while empty
//   count_o           number of valid entries ($clog2(DEPTH)+1 bits)
//   head_o            head entry, all zero while empty
module polaris_fetch_fifo
  import polaris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (do_pop) rd_d = rd_q + PW'(1);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count_q says so.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/polaris_fetch_queue.sv
// Autonomous instruction prefetcher for the Polaris core.
// Issues back-to-back 32-bit I-master reads and buffers {pc, instruction}
// pairs in a DEPTH-entry queue that the sequencer pops; redirects flush the
// queue and restart fetching at a new address.
// Ports:
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   iack_i, idat_i         I-master acknowledge and read data
//   iadr_o, isiz_o         I-master request (isiz_o 2'b10 = word read, 00 = idle)
//   redirect_i,
//   redirect_pc_i          flush and restart fetch at redirect_pc_i
//   pop_i                  consumer takes the head entry
//   ir_valid_o, ir_o,
//   ir_pc_o                head entry (zero while empty)
//   misalign_o             sticky misaligned-redirect flag
// Build option: define POLARIS_FETCH_MISALIGN_TRAP_EN to trap misaligned
// redirect targets (sticky misalign_o, fetching stops until an aligned
// redirect). Without it the low two target bits are cleared silently and
// misalign_o is tied low.
module polaris_fetch_queue
  import polaris_pkg::*;
#(
  parameter int          AW           = 64,
  parameter int          DEPTH        = 4,
  parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          iack_i,
  input  logic [31:0]   idat_i,
  output logic [AW-1:0] iadr_o,
  output logic [1:0]    isiz_o,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic          pop_i,
  output logic          ir_valid_o,
  output logic [31:0]   ir_o,
  output logic [AW-1:0] ir_pc_o,
  output logic          misalign_o
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] RV   = RESET_VECTOR[AW-1:0];

  fetch_state_e  state_q;
  logic [AW-1:0] fpc_q;
  logic [AW-1:0] iadr_q;
  logic [1:0]    isiz_q;

  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop_eff;
  logic [AW-1:0] target;
  logic [AW-1:0] fpc_inc;
  logic          redir_bad;
  logic          fetch_hold;

  // Data acked while a redirect is present belongs to the old stream.
  assign push    = (state_q == FS_FETCH) && iack_i && !redirect_i;
  assign pop_eff = pop_i && (count != '0) && !redirect_i;
  assign target  = {redirect_pc_i[AW-1:2], 2'b00};
  assign fpc_inc = fpc_q + AW'(4);

  // Occupancy after this cycle's push/pop; lets IDLE restart fetching in the
  // same cycle a pop frees a slot.
  always_comb begin
    count_after = count + CW'(push) - CW'(pop_eff);
  end

  assign push_entry.pc    = 64'(fpc_q);
  assign push_entry.instr = idat_i;

`ifdef POLARIS_FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

  // Every redirect re-evaluates the flag: misaligned sets it, aligned clears it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= redir_bad;
    end
  end

  assign fetch_hold = misalign_q;
  assign misalign_o = misalign_q;
`else
  logic unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc_i[1:0];
  assign redir_bad    = 1'b0;
  assign fetch_hold   = 1'b0;
  assign misalign_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= FS_IDLE;
      fpc_q   <= RV;
      iadr_q  <= '0;
      isiz_q  <= ISIZ_NONE;
    end else if (redir_bad) begin
      // Trapped target: stop fetching until an aligned redirect arrives.
      state_q <= FS_IDLE;
      iadr_q  <= '0;
      isiz_q  <= ISIZ_NONE;
    end else if (redirect_i) begin
      fpc_q <= target;
      if ((state_q != FS_IDLE) && !iack_i) begin
        // Bus cycle still open: let it finish at the old address.
        state_q <= FS_DISCARD;
      end else begin
        state_q <= FS_FETCH;
        iadr_q  <= target;
        isiz_q  <= ISIZ_WORD;
      end
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (!fetch_hold && (count_after < FULL)) begin
            state_q <= FS_FETCH;
            iadr_q  <= fpc_q;
            isiz_q  <= ISIZ_WORD;
          end
        end
        FS_FETCH: begin
          if (iack_i) begin
            fpc_q <= fpc_inc;
            if (count_after == FULL) begin
              state_q <= FS_IDLE;
              iadr_q  <= '0;
              isiz_q  <= ISIZ_NONE;
            end else begin
              iadr_q <= fpc_inc;
            end
          end
        end
        FS_DISCARD: begin
          // Queue was flushed on entry and cannot fill here, so refetch directly.
          if (iack_i) begin
            state_q <= FS_FETCH;
            iadr_q  <= fpc_q;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          iadr_q  <= '0;
          isiz_q  <= ISIZ_NONE;
        end
      endcase
    end
  end

  polaris_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .flush_i  (redirect_i),
    .push_i   (push),
    .entry_i  (push_entry),
    .pop_i    (pop_eff),
    .count_o  (count),
    .head_o   (head)
  );

  assign iadr_o     = iadr_q;
  assign isiz_o     = isiz_q;
  assign ir_valid_o = (count != '0);
  assign ir_o       = head.instr;
  assign ir_pc_o    = head.pc[AW-1:0];

endmodule

// File: tb/tb_polaris_fetch_queue.sv
module tb_polaris_fetch_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        iack_i;
  logic [31:0] idat_i;
  logic [63:0] iadr_o;
  logic [1:0]  isiz_o;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        pop_i;
  logic        ir_valid_o;
  logic [31:0] ir_o;
  logic [63:0] ir_pc_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

  polaris_fetch_queue dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .iack_i        (iack_i),
    .idat_i        (idat_i),
    .iadr_o        (iadr_o),
    .isiz_o        (isiz_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pop_i         (pop_i),
    .ir_valid_o    (ir_valid_o),
    .ir_o          (ir_o),
    .ir_pc_o       (ir_pc_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_ni      = 1'b0;
    iack_i        = 1'b0;
    idat_i        = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    pop_i         = 1'b0;
    step();
    step();

    // Reset state
    check("rst_isiz", 64'(isiz_o), 64'h0);
    check("rst_iadr", iadr_o, 64'h0);
    check("rst_valid", 64'(ir_valid_o), 64'h0);
    check("rst_ir", 64'(ir_o), 64'h0);
    check("rst_irpc", ir_pc_o, 64'h0);
    check("rst_misalign", 64'(misalign_o), 64'h0);

    // 1: fill the queue with iack held high
    reset_ni = 1'b1;
    iack_i   = 1'b1;
    idat_i   = 32'h0000_0013;
    step();
    check("t1_req0_iadr", iadr_o, RV);
    check("t1_req0_isiz", 64'(isiz_o), 64'h2);
    check("t1_req0_valid", 64'(ir_valid_o), 64'h0);
    step();
    check("t1_push0_valid", 64'(ir_valid_o), 64'h1);
    check("t1_push0_irpc", ir_pc_o, RV);
    check("t1_push0_ir", 64'(ir_o), 64'h0000_0013);
    check("t1_req1_iadr", iadr_o, RV + 64'h4);
    idat_i = 32'h0010_0093;
    step();
    check("t1_req2_iadr", iadr_o, RV + 64'h8);
    idat_i = 32'h0020_0113;
    step();
    check("t1_req3_iadr", iadr_o, RV + 64'hC);
    idat_i = 32'h0030_0193;
    step();
    check("t1_full_isiz", 64'(isiz_o), 64'h0);
    check("t1_full_iadr", iadr_o, 64'h0);
    check("t1_full_irpc", ir_pc_o, RV);
    check("t1_full_valid", 64'(ir_valid_o), 64'h1);

    // 2: one pop frees one slot
    iack_i = 1'b0;
    pop_i  = 1'b1;
    step();
    check("t2_req_iadr", iadr_o, RV + 64'h10);
    check("t2_req_isiz", 64'(isiz_o), 64'h2);
    check("t2_head_pc", ir_pc_o, RV + 64'h4);
    check("t2_head_ir", 64'(ir_o), 64'h0010_0093);
    pop_i  = 1'b0;
    iack_i = 1'b1;
    idat_i = 32'h0040_0213;
    step();
    check("t2_refull_isiz", 64'(isiz_o), 64'h0);
    check("t2_refull_irpc", ir_pc_o, RV + 64'h4);

    // 3: redirect while a request is pending
    iack_i = 1'b0;
    pop_i  = 1'b1;
    step();
    check("t3_req_iadr", iadr_o, RV + 64'h14);
    check("t3_pop_irpc", ir_pc_o, RV + 64'h8);
    pop_i = 1'b0;
    step();
    check("t3_hold_iadr", iadr_o, RV + 64'h14);
    check("t3_hold_isiz", 64'(isiz_o), 64'h2);
    check("t3_hold_valid", 64'(ir_valid_o), 64'h1);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h124;
    step();
    check("t3_disc_iadr", iadr_o, RV + 64'h14);
    check("t3_disc_isiz", 64'(isiz_o), 64'h2);
    check("t3_disc_valid", 64'(ir_valid_o), 64'h0);
    check("t3_disc_ir", 64'(ir_o), 64'h0);
    redirect_i = 1'b0;
    step();
    check("t3_disc2_iadr", iadr_o, RV + 64'h14);
    iack_i = 1'b1;
    idat_i = 32'hDEAD_BEEF;
    step();
    check("t3_new_iadr", iadr_o, 64'h124);
    check("t3_drop_valid", 64'(ir_valid_o), 64'h0);

    // 4: redirect coinciding with an ack
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h200;
    idat_i        = 32'h1111_1111;
    step();
    check("t4_iadr", iadr_o, 64'h200);
    check("t4_valid", 64'(ir_valid_o), 64'h0);

    // 5: address wrap at the top of the address space
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("t5_iadr", iadr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_i = 1'b0;
    idat_i     = 32'hA1A1_A1A1;
    step();
    check("t5_e0_pc", ir_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_e0_ir", 64'(ir_o), 64'hA1A1_A1A1);
    check("t5_wrap_iadr", iadr_o, 64'h0);
    check("t5_wrap_isiz", 64'(isiz_o), 64'h2);
    idat_i = 32'hA2A2_A2A2;
    step();
    check("t5_next_iadr", iadr_o, 64'h4);
    iack_i = 1'b0;
    pop_i  = 1'b1;
    step();
    check("t5_e1_pc", ir_pc_o, 64'h0);
    check("t5_e1_ir", 64'(ir_o), 64'hA2A2_A2A2);
    check("t5_e1_valid", 64'(ir_valid_o), 64'h1);
    step();
    check("t5_empty_valid", 64'(ir_valid_o), 64'h0);
    check("t5_empty_ir", 64'(ir_o), 64'h0);
    step();
    check("pop_empty_valid", 64'(ir_valid_o), 64'h0);
    pop_i  = 1'b0;
    iack_i = 1'b1;
    idat_i = 32'hB1B1_B1B1;
    step();
    check("after_empty_pc", ir_pc_o, 64'h4);
    check("after_empty_ir", 64'(ir_o), 64'hB1B1_B1B1);
    check("after_empty_iadr", iadr_o, 64'h8);

    // Simultaneous push and pop
    pop_i  = 1'b1;
    idat_i = 32'hB2B2_B2B2;
    step();
    check("pushpop_pc", ir_pc_o, 64'h8);
    check("pushpop_ir", 64'(ir_o), 64'hB2B2_B2B2);
    check("pushpop_valid", 64'(ir_valid_o), 64'h1);
    check("pushpop_iadr", iadr_o, 64'hC);

    // 6: misaligned redirect target
    pop_i         = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h126;
    step();
    check("t6_flush_valid", 64'(ir_valid_o), 64'h0);
`ifdef POLARIS_FETCH_MISALIGN_TRAP_EN
    check("t6_misalign_set", 64'(misalign_o), 64'h1);
    check("t6_trap_isiz", 64'(isiz_o), 64'h0);
`else
    check("t6_misalign_tied", 64'(misalign_o), 64'h0);
    check("t6_trunc_iadr", iadr_o, 64'h124);
`endif
    redirect_i = 1'b0;
    iack_i     = 1'b0;
    step();
`ifdef POLARIS_FETCH_MISALIGN_TRAP_EN
    check("t6_trap_hold_isiz", 64'(isiz_o), 64'h0);
    check("t6_misalign_sticky", 64'(misalign_o), 64'h1);
`else
    check("t6_trunc_hold_iadr", iadr_o, 64'h124);
`endif
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h128;
    iack_i        = 1'b1;
    step();
    check("t6_aligned_iadr", iadr_o, 64'h128);
    check("t6_aligned_isiz", 64'(isiz_o), 64'h2);
    check("t6_misalign_clr", 64'(misalign_o), 64'h0);
    redirect_i = 1'b0;
    idat_i     = 32'hC1C1_C1C1;
    step();
    check("t6_push_pc", ir_pc_o, 64'h128);
    check("t6_push_valid", 64'(ir_valid_o), 64'h1);

    // Asynchronous reset in the middle of a bus cycle
    #3;
    reset_ni = 1'b0;
    #1;
    check("async_rst_isiz", 64'(isiz_o), 64'h0);
    check("async_rst_iadr", iadr_o, 64'h0);
    check("async_rst_valid", 64'(ir_valid_o), 64'h0);
    check("async_rst_irpc", ir_pc_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
